dmem_responder: RTL and testbench

Responder side of the CPU data-memory port. The pipeline's MEM stage issues load and store requests over a valid/ready handshake. This block accepts one request at a time, waits a programmable access latency, then performs the byte, half or word access selected by funct3. It returns the load data, sign- or zero-extended, on a response channel held until the CPU accepts it. It replaces the single-cycle data memory so the hazard unit can be tested against multi-cycle memory.

---
 rtl/dmem_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the CPU data-memory port.
// Accepts one load/store at a time over a valid/ready handshake and waits
// LATENCY cycles. It then performs the byte/half/word access selected by
// funct3 and holds the response until the CPU takes it.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [3:0] LAT_C = 4'(LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Access is illegal for an unknown funct3 in the given direction or a
    // misaligned half/word.
    function automatic logic access_err_f(input logic       we,
                                          input logic [2:0] f3,
                                          input logic [1:0] lane);
        logic err;
        err = 1'b1;
        case (f3)
            3'b000:  err = 1'b0;
            3'b001:  err = lane[0];
            3'b010:  err = (lane != 2'b00);
            3'b100:  err = we;
            3'b101:  err = we | lane[0];
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Extract and extend the load result from a little-endian word.
    function automatic logic [31:0] load_ext_f(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'b00:   b = word[7:0];
            2'b01:   b = word[15:8];
            2'b10:   b = word[23:16];
            default: b = word[31:24];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merge store data into the old word; untouched bytes keep their value.
    function automatic logic [31:0] store_merge_f(input logic [31:0] old,
                                                  input logic [31:0] wd,
                                                  input logic [2:0]  f3,
                                                  input logic [1:0]  lane);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000: begin
                case (lane)
                    2'b00:   r[7:0]   = wd[7:0];
                    2'b01:   r[15:8]  = wd[7:0];
                    2'b10:   r[23:16] = wd[7:0];
                    default: r[31:24] = wd[7:0];
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            3'b010:  r = wd;
            default: r = old;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH];

    logic [AW-1:0] idx_s;
    logic [31:0]   mem_rd_s;
    logic          acc_err_s;
    logic [31:0]   load_data_s;
    logic [31:0]   merge_s;
    logic          mem_we_s;

    // Upper address bits above the index are ignored, so addresses wrap.
    assign idx_s       = addr_q[AW+1:2];
    assign mem_rd_s    = mem_q[idx_s];
    assign acc_err_s   = access_err_f(we_q, funct3_q, addr_q[1:0]);
    assign load_data_s = load_ext_f(mem_rd_s, funct3_q, addr_q[1:0]);
    assign merge_s     = store_merge_f(mem_rd_s, wdata_q, funct3_q, addr_q[1:0]);

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and next-output logic of the request/wait/response FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    we_d        = req_we;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    funct3_d    = req_funct3;
                    // A zero count makes the next edge the access edge, so
                    // LATENCY=0 needs no separate path.
                    cnt_d       = LAT_C;
                    req_ready_d = 1'b0;
                    state_d     = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rsp_err_d   = acc_err_s;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                    if (!we_q && !acc_err_s) begin
                        rsp_rdata_d = load_data_s;
                    end else begin
                        rsp_rdata_d = 32'd0;
                    end
                    mem_we_s = we_q & ~acc_err_s;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'd0;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // FSM state, latched request and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 8'd0;
            wdata_q     <= 32'd0;
            funct3_q    <= 3'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Word storage: cleared on reset, written only on a legal store's access edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we_s) begin
            mem_q[idx_s] <= merge_s;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=0
// instance share stimulus; sel chooses which one is driven and observed.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        req_valid, req_we, rsp_ready;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;

    logic        a_req_valid, a_rsp_ready, a_req_ready, a_rsp_valid, a_rsp_err;
    logic        b_req_valid, b_rsp_ready, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;

    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;
    int          lat;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign a_rsp_ready = rsp_ready & ~sel;
    assign b_rsp_ready = rsp_ready & sel;
    assign o_req_ready = sel ? b_req_ready : a_req_ready;
    assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;
    assign lat         = sel ? 0 : 2;

    dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int          tests = 0;
    int          fails = 0;
    logic [32:0] sb[$];   // {err, rdata}

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [32:0] e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " rdata"}, o_rsp_rdata, e[31:0]);
            chk({tag, " err"}, {31'd0, o_rsp_err}, {31'd0, e[32]});
        end else begin
            chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int n;
        n = 0;
        while (o_rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), 32'(lat + 1));
    endtask

    task automatic handshake(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid cleared"}, {31'd0, o_rsp_valid}, 32'd0);
        chk({tag, " req_ready back"}, {31'd0, o_req_ready}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [7:0] addr,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        req_valid = 1'b1;
        chk({tag, " req_ready"}, {31'd0, o_req_ready}, 32'd1);
        sb.push_back({exp_err, exp_rd});
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(tag);
        pop_chk(tag);
        handshake(tag);
    endtask

    initial begin
        int cnt;
        rst = 1'b0; sel = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 8'd0; req_wdata = 32'd0; req_funct3 = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("reset rsp_rdata", o_rsp_rdata, 32'd0);
        chk("reset rsp_err", {31'd0, o_rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Basic word store/load, then sub-word merging and extension.
        do_req("SW 08", 1'b1, 8'h08, 32'hDEADBEEF, 3'b010, 32'd0, 1'b0);
        do_req("LW 08", 1'b0, 8'h08, 32'd0, 3'b010, 32'hDEADBEEF, 1'b0);
        do_req("SW 08b", 1'b1, 8'h08, 32'h11223344, 3'b010, 32'd0, 1'b0);
        do_req("SB 09", 1'b1, 8'h09, 32'h00000080, 3'b000, 32'd0, 1'b0);
        do_req("LW 08 merged", 1'b0, 8'h08, 32'd0, 3'b010, 32'h11228044, 1'b0);
        do_req("LB 09", 1'b0, 8'h09, 32'd0, 3'b000, 32'hFFFFFF80, 1'b0);
        do_req("LBU 09", 1'b0, 8'h09, 32'd0, 3'b100, 32'h00000080, 1'b0);
        do_req("LH 0A", 1'b0, 8'h0A, 32'd0, 3'b001, 32'h00001122, 1'b0);
        do_req("LH 08", 1'b0, 8'h08, 32'd0, 3'b001, 32'hFFFF8044, 1'b0);
        do_req("LHU 08", 1'b0, 8'h08, 32'd0, 3'b101, 32'h00008044, 1'b0);
        do_req("SH 0E", 1'b1, 8'h0E, 32'h1234ABCD, 3'b001, 32'd0, 1'b0);
        do_req("LW 0C", 1'b0, 8'h0C, 32'd0, 3'b010, 32'hABCD0000, 1'b0);

        // Error cases: same latency, zero data, storage untouched.
        do_req("LW 0A misaligned", 1'b0, 8'h0A, 32'd0, 3'b010, 32'd0, 1'b1);
        do_req("SH 0B misaligned", 1'b1, 8'h0B, 32'h0000FFFF, 3'b001, 32'd0, 1'b1);
        do_req("LW 08 unchanged", 1'b0, 8'h08, 32'd0, 3'b010, 32'h11228044, 1'b0);
        do_req("load f3 011", 1'b0, 8'h08, 32'd0, 3'b011, 32'd0, 1'b1);
        do_req("store f3 100", 1'b1, 8'h08, 32'hFFFFFFFF, 3'b100, 32'd0, 1'b1);
        do_req("LW 08 after bad store", 1'b0, 8'h08, 32'd0, 3'b010, 32'h11228044, 1'b0);

        // Backpressure with a second request held pending.
        @(negedge clk);
        req_we = 1'b0; req_addr = 8'h08; req_funct3 = 3'b010; req_valid = 1'b1;
        sb.push_back({1'b0, 32'h11228044});
        @(posedge clk); #1;
        req_addr = 8'h09; req_funct3 = 3'b100;
        wait_rsp("bp first");
        pop_chk("bp first");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp hold valid", {31'd0, o_rsp_valid}, 32'd1);
            chk("bp hold rdata", o_rsp_rdata, 32'h11228044);
            chk("bp hold req_ready", {31'd0, o_req_ready}, 32'd0);
        end
        sb.push_back({1'b0, 32'h00000080});
        handshake("bp release");
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp second accepted", {31'd0, o_req_ready}, 32'd0);
        wait_rsp("bp second");
        pop_chk("bp second");
        handshake("bp second");

        // Zero-latency instance.
        sel = 1'b1;
        #1;
        chk("lat0 reset req_ready", {31'd0, o_req_ready}, 32'd1);
        do_req("lat0 SW 20", 1'b1, 8'h20, 32'h12345678, 3'b010, 32'd0, 1'b0);
        do_req("lat0 LW 20", 1'b0, 8'h20, 32'd0, 3'b010, 32'h12345678, 1'b0);
        @(negedge clk);
        req_we = 1'b0; req_addr = 8'h20; req_funct3 = 3'b010;
        req_valid = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back({1'b0, 32'h12345678});
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (o_rsp_valid === 1'b1) begin
                cnt++;
                pop_chk("lat0 b2b");
            end
        end
        req_valid = 1'b0;
        chk("lat0 b2b count", 32'(cnt), 32'd3);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Asynchronous reset during the wait of a store.
        sel = 1'b0;
        @(negedge clk);
        req_we = 1'b1; req_addr = 8'h10; req_wdata = 32'hCAFEBABE; req_funct3 = 3'b010;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #2;
        chk("in wait req_ready", {31'd0, o_req_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("async rst req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("async rst rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("async rst rsp_rdata", o_rsp_rdata, 32'd0);
        chk("async rst rsp_err", {31'd0, o_rsp_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_req("LW 10 after rst", 1'b0, 8'h10, 32'd0, 3'b010, 32'd0, 1'b0);
        do_req("LW 08 after rst", 1'b0, 8'h08, 32'd0, 3'b010, 32'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
